wb_commit: RTL



---
 rtl/wb_commit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/wb_commit.sv
// Write-back commit: merges the MEM/WB slot and a small long-latency result queue onto the
// single register-file write port. Define WB_LR_BYPASS_EN to let an idle port take lr_* directly.
module wb_commit #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int LRQ_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         mem_we,
  input  logic [ADDR_W-1:0]            mem_waddr,
  input  logic [DATA_W-1:0]            mem_wdata,
  input  logic                         lr_valid,
  output logic                         lr_ready,
  input  logic [ADDR_W-1:0]            lr_waddr,
  input  logic [DATA_W-1:0]            lr_wdata,
  output logic                         we,
  output logic [ADDR_W-1:0]            waddr,
  output logic [DATA_W-1:0]            wdata,
  output logic [$clog2(LRQ_DEPTH):0]   lrq_count,
  output logic                         wb_src
);

  localparam int PTR_W = $clog2(LRQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              p_pend;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_data;

  logic [ADDR_W-1:0] q_addr [LRQ_DEPTH];
  logic [DATA_W-1:0] q_data [LRQ_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic q_empty;
  logic bypass;
  logic pop;
  logic push;

  assign q_empty   = (count == '0);
  assign lr_ready  = (count != CNT_W'(LRQ_DEPTH));
  assign lrq_count = count;

`ifdef WB_LR_BYPASS_EN
  assign bypass = !p_pend && q_empty && lr_valid && (lr_waddr != '0);
`else
  assign bypass = 1'b0;
`endif

  // The slot always has priority, so the queue head only moves when the slot is idle.
  assign pop  = !p_pend && !q_empty;
  assign push = lr_valid && lr_ready && (lr_waddr != '0) && !bypass;

  always_comb begin
    we     = 1'b0;
    waddr  = '0;
    wdata  = '0;
    wb_src = 1'b0;
    if (p_pend) begin
      we    = 1'b1;
      waddr = p_addr;
      wdata = p_data;
    end else if (!q_empty) begin
      we     = 1'b1;
      waddr  = q_addr[head];
      wdata  = q_data[head];
      wb_src = 1'b1;
    end else if (bypass) begin
      we     = 1'b1;
      waddr  = lr_waddr;
      wdata  = lr_wdata;
      wb_src = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_pend <= 1'b0;
      p_addr <= '0;
      p_data <= '0;
    end else if (flush) begin
      p_pend <= 1'b0;
      p_addr <= '0;
      p_data <= '0;
    end else if (stall) begin
      // A pending slot is always on the port, so by the edge it has been written.
      p_pend <= 1'b0;
    end else begin
      p_pend <= mem_we && (mem_waddr != '0);
      p_addr <= mem_waddr;
      p_data <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)
        head <= head + PTR_W'(1);
      if (push)
        tail <= tail + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= lr_waddr;
      q_data[tail] <= lr_wdata;
    end
  end

endmodule
